imm_alu_sequencer: RTL and testbench

- Synthesisable control unit that replaces the hand-stepped bench sequencing of the Datapath for immediate-ALU instructions (addi, andi, ori).
- Drives the Datapath control strobes through an optional register-preload phase, then the fetch/execute steps T0–T5.
- Parametrised in preload register count, preload base register and continuous-run mode.
- Sits between the top level and Datapath; reads IR opcode bits back from Datapath.

---
 rtl/imm_alu_sequencer.sv | 129 ++++++++++++
 tb/tb_imm_alu_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/imm_alu_sequencer.sv
// Control sequencer for immediate-ALU instructions (addi/andi/ori): optional
// register preload from consecutive memory words, then fetch/execute T0-T5.
module imm_alu_sequencer #(
  parameter int NUM_PRELOAD  = 2,
  parameter int PRELOAD_BASE = 5,
  parameter int RUN_CONT     = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        preload_en,
  input  logic        run,
  input  logic [4:0]  ir_opcode,
  output logic        PC_out,
  output logic        MAR_rd,
  output logic        MDR_rd,
  output logic        MDR_out,
  output logic        Read,
  output logic        IncPC,
  output logic        IR_rd,
  output logic        Y_rd,
  output logic        Zlo_rd,
  output logic        Zlo_out,
  output logic        PC_rd,
  output logic        Gra,
  output logic        Grb,
  output logic        BAout,
  output logic        R_out,
  output logic        C_out,
  output logic        Rin,
  output logic [15:0] R_rd,
  output logic [4:0]  op_sel,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_LA, S_LB, S_LC, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_ILL
  } state_t;

  localparam int LAST_K = (NUM_PRELOAD > 0) ? NUM_PRELOAD - 1 : 0;
  localparam logic [2:0] LAST_K3 = 3'(LAST_K);

  state_t     state_reg, state_next;
  logic [2:0] k_reg, k_next;
  logic [4:0] alu_op_reg, alu_op_next;
  logic       legal;
  logic [4:0] alu_op_dec;

  always_comb begin
    legal      = 1'b1;
    alu_op_dec = 5'b00000;
    case (ir_opcode)
      5'b01100: alu_op_dec = 5'b00011;
      5'b01101: alu_op_dec = 5'b00101;
      5'b01110: alu_op_dec = 5'b00110;
      default:  legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg  <= S_IDLE;
      k_reg      <= 3'd0;
      alu_op_reg <= 5'b00000;
    end else begin
      state_reg  <= state_next;
      k_reg      <= k_next;
      alu_op_reg <= alu_op_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    alu_op_next = alu_op_reg;
    case (state_reg)
      S_IDLE: begin
        k_next = 3'd0;
        if (start) state_next = (preload_en && NUM_PRELOAD > 0) ? S_LA : S_T0;
      end
      S_LA: state_next = S_LB;
      S_LB: state_next = S_LC;
      S_LC: begin
        k_next     = k_reg + 3'd1;
        state_next = (k_reg == LAST_K3) ? S_T0 : S_LA;
      end
      S_T0: state_next = S_T1;
      S_T1: state_next = S_T2;
      S_T2: state_next = S_T3;
      S_T3: begin
        alu_op_next = alu_op_dec;
        state_next  = legal ? S_T4 : S_ILL;
      end
      S_T4: state_next = S_T5;
      S_T5: state_next = (RUN_CONT != 0 && run) ? S_T0 : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    PC_out = 1'b0; MAR_rd = 1'b0; MDR_rd = 1'b0; MDR_out = 1'b0;
    Read = 1'b0; IncPC = 1'b0; IR_rd = 1'b0; Y_rd = 1'b0;
    Zlo_rd = 1'b0; Zlo_out = 1'b0; PC_rd = 1'b0; Gra = 1'b0;
    Grb = 1'b0; BAout = 1'b0; R_out = 1'b0; C_out = 1'b0; Rin = 1'b0;
    op_sel = 5'b00000; done = 1'b0; illegal = 1'b0;
    busy = (state_reg != S_IDLE);
    case (state_reg)
      S_LA: begin PC_out = 1'b1; MAR_rd = 1'b1; end
      S_LB: begin Read = 1'b1; MDR_rd = 1'b1; end
      S_LC: begin MDR_out = 1'b1; IncPC = 1'b1; end
      S_T0: begin PC_out = 1'b1; MAR_rd = 1'b1; IncPC = 1'b1; Zlo_rd = 1'b1; end
      S_T1: begin Zlo_out = 1'b1; PC_rd = 1'b1; Read = 1'b1; MDR_rd = 1'b1; end
      S_T2: begin MDR_out = 1'b1; IR_rd = 1'b1; end
      S_T3: if (legal) begin Grb = 1'b1; BAout = 1'b1; R_out = 1'b1; Y_rd = 1'b1; end
      S_T4: begin C_out = 1'b1; Zlo_rd = 1'b1; op_sel = alu_op_reg; end
      S_T5: begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
      S_ILL: illegal = 1'b1;
      default: ;
    endcase
  end

  // One-hot direct load of R[PRELOAD_BASE+k] during the write-back step of preload.
  for (genvar gi = 0; gi < 16; gi++) begin : g_rrd
    assign R_rd[gi] = (state_reg == S_LC) && (PRELOAD_BASE + int'(k_reg) == gi);
  end

endmodule

// File: tb/tb_imm_alu_sequencer.sv
// Directed bench for imm_alu_sequencer: cycle-by-cycle strobe vectors plus
// hand sequences for reset-in-preload and continuous-run mode.
module tb_imm_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr = 1'b1, start = 1'b0, preload_en = 1'b0, run = 1'b0;
  logic [4:0] ir_opcode = 5'b0;
  logic PC_out, MAR_rd, MDR_rd, MDR_out, Read, IncPC, IR_rd, Y_rd, Zlo_rd, Zlo_out, PC_rd;
  logic Gra, Grb, BAout, R_out, C_out, Rin, busy, done, illegal;
  logic [15:0] R_rd;
  logic [4:0] op_sel;

  imm_alu_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .preload_en(preload_en), .run(run),
    .ir_opcode(ir_opcode), .PC_out(PC_out), .MAR_rd(MAR_rd), .MDR_rd(MDR_rd),
    .MDR_out(MDR_out), .Read(Read), .IncPC(IncPC), .IR_rd(IR_rd), .Y_rd(Y_rd),
    .Zlo_rd(Zlo_rd), .Zlo_out(Zlo_out), .PC_rd(PC_rd), .Gra(Gra), .Grb(Grb),
    .BAout(BAout), .R_out(R_out), .C_out(C_out), .Rin(Rin), .R_rd(R_rd),
    .op_sel(op_sel), .busy(busy), .done(done), .illegal(illegal)
  );

  logic start_c = 1'b0, run_c = 1'b0;
  logic [4:0] op_c = 5'b01100;
  logic pco_c, mar_c, mdrr_c, mdro_c, read_c, inc_c, ir_c, y_c, zrd_c, zout_c, pcrd_c;
  logic gra_c, grb_c, ba_c, ro_c, co_c, rin_c, busy_c, done_c, ill_c;
  logic [15:0] rrd_c;
  logic [4:0] opsel_c;

  imm_alu_sequencer #(.NUM_PRELOAD(2), .PRELOAD_BASE(5), .RUN_CONT(1)) dut_c (
    .clk(clk), .clr(clr), .start(start_c), .preload_en(1'b0), .run(run_c),
    .ir_opcode(op_c), .PC_out(pco_c), .MAR_rd(mar_c), .MDR_rd(mdrr_c),
    .MDR_out(mdro_c), .Read(read_c), .IncPC(inc_c), .IR_rd(ir_c), .Y_rd(y_c),
    .Zlo_rd(zrd_c), .Zlo_out(zout_c), .PC_rd(pcrd_c), .Gra(gra_c), .Grb(grb_c),
    .BAout(ba_c), .R_out(ro_c), .C_out(co_c), .Rin(rin_c), .R_rd(rrd_c),
    .op_sel(opsel_c), .busy(busy_c), .done(done_c), .illegal(ill_c)
  );

  // Packed observation: 17 strobes, R_rd, op_sel, busy, done, illegal.
  wire [40:0] act = {PC_out, MAR_rd, MDR_rd, MDR_out, Read, IncPC, IR_rd, Y_rd, Zlo_rd,
                     Zlo_out, PC_rd, Gra, Grb, BAout, R_out, C_out, Rin,
                     R_rd, op_sel, busy, done, illegal};

  localparam logic [16:0] B_PCO = 17'h10000, B_MAR = 17'h08000, B_MDRR = 17'h04000,
    B_MDRO = 17'h02000, B_READ = 17'h01000, B_INC = 17'h00800, B_IR = 17'h00400,
    B_Y = 17'h00200, B_ZRD = 17'h00100, B_ZOUT = 17'h00080, B_PCRD = 17'h00040,
    B_GRA = 17'h00020, B_GRB = 17'h00010, B_BA = 17'h00008, B_RO = 17'h00004,
    B_CO = 17'h00002, B_RIN = 17'h00001;

  typedef struct {
    logic        start;
    logic        pre;
    logic [4:0]  op;
    logic [40:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  function automatic logic [40:0] pk(logic [16:0] s, logic [15:0] r, logic [4:0] o,
                                     logic b, logic d, logic il);
    return {s, r, o, b, d, il};
  endfunction

  task automatic add(logic st, logic pre, logic [4:0] op, logic [40:0] e, string nm);
    vec_t v;
    v.start = st; v.pre = pre; v.op = op; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic add_preload(logic [4:0] op);
    add(1'b1, 1'b1, op, pk(B_PCO | B_MAR, 16'h0, 5'h0, 1, 0, 0), "LA0");
    add(1'b0, 1'b0, op, pk(B_READ | B_MDRR, 16'h0, 5'h0, 1, 0, 0), "LB0");
    add(1'b0, 1'b0, op, pk(B_MDRO | B_INC, 16'h0020, 5'h0, 1, 0, 0), "LC0");
    add(1'b0, 1'b0, op, pk(B_PCO | B_MAR, 16'h0, 5'h0, 1, 0, 0), "LA1");
    add(1'b0, 1'b0, op, pk(B_READ | B_MDRR, 16'h0, 5'h0, 1, 0, 0), "LB1");
    add(1'b0, 1'b0, op, pk(B_MDRO | B_INC, 16'h0040, 5'h0, 1, 0, 0), "LC1");
  endtask

  task automatic add_fetch(logic st, logic [4:0] op);
    add(st,   1'b0, op, pk(B_PCO | B_MAR | B_INC | B_ZRD, 16'h0, 5'h0, 1, 0, 0), "T0");
    add(1'b0, 1'b0, op, pk(B_ZOUT | B_PCRD | B_READ | B_MDRR, 16'h0, 5'h0, 1, 0, 0), "T1");
    add(1'b0, 1'b0, op, pk(B_MDRO | B_IR, 16'h0, 5'h0, 1, 0, 0), "T2");
  endtask

  task automatic add_exec(logic [4:0] op, logic [4:0] opsel);
    add(1'b0, 1'b0, op, pk(B_GRB | B_BA | B_RO | B_Y, 16'h0, 5'h0, 1, 0, 0), "T3");
    add(1'b0, 1'b0, op, pk(B_CO | B_ZRD, 16'h0, opsel, 1, 0, 0), "T4");
    add(1'b0, 1'b0, op, pk(B_ZOUT | B_GRA | B_RIN, 16'h0, 5'h0, 1, 1, 0), "T5");
    add(1'b0, 1'b0, op, pk(17'h0, 16'h0, 5'h0, 0, 0, 0), "IDLE");
  endtask

  task automatic check(string nm, logic [40:0] a, logic [40:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end else begin
      $display("ok   %s value=%h", nm, a);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int cyc, done_first, done_second, done_cnt;

  initial begin
    // Preload + addi, then andi and ori without preload, then an illegal opcode.
    add_preload(5'b01100); add_fetch(1'b0, 5'b01100); add_exec(5'b01100, 5'b00011);
    add_fetch(1'b1, 5'b01101); add_exec(5'b01101, 5'b00101);
    add_fetch(1'b1, 5'b01110); add_exec(5'b01110, 5'b00110);
    add_fetch(1'b1, 5'b00011);
    add(1'b0, 1'b0, 5'b00011, pk(17'h0, 16'h0, 5'h0, 1, 0, 0), "T3_ill");
    add(1'b0, 1'b0, 5'b00011, pk(17'h0, 16'h0, 5'h0, 1, 0, 1), "ILLEGAL");
    add(1'b0, 1'b0, 5'b00011, pk(17'h0, 16'h0, 5'h0, 0, 0, 0), "IDLE_after_ill");
    add(1'b0, 1'b1, 5'b01100, pk(17'h0, 16'h0, 5'h0, 0, 0, 0), "IDLE_hold");

    // Reset held with start high: nothing may leave IDLE.
    clr = 1'b1; start = 1'b1; preload_en = 1'b1;
    step(); check("reset_c1", act, 41'h0);
    step(); check("reset_c2", act, 41'h0);
    clr = 1'b0; start = 1'b0; preload_en = 1'b0;
    step(); check("idle_after_reset", act, 41'h0);

    foreach (vecs[i]) begin
      start = vecs[i].start; preload_en = vecs[i].pre; ir_opcode = vecs[i].op;
      step();
      check($sformatf("vec%0d_%s", i, vecs[i].name), act, vecs[i].exp);
    end
    start = 1'b0; preload_en = 1'b0;

    // Reset during L_B of k=1, then a fresh preload must restart at k=0.
    start = 1'b1; preload_en = 1'b1; ir_opcode = 5'b01100;
    step(); start = 1'b0; preload_en = 1'b0;
    repeat (4) step();
    check("mid_LB1", act, pk(B_READ | B_MDRR, 16'h0, 5'h0, 1, 0, 0));
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_in_preload", act, 41'h0);
    start = 1'b1; preload_en = 1'b1;
    step(); start = 1'b0; preload_en = 1'b0;
    cyc = 1; done_first = 0;
    check("restart_LA0", act, pk(B_PCO | B_MAR, 16'h0, 5'h0, 1, 0, 0));
    step(); step(); cyc = 3;
    check("restart_LC0_rrd5", {16'h0, R_rd}, {16'h0, 16'h0020});
    while (!done && cyc < 30) begin step(); cyc++; end
    check("restart_done_cycle", 41'(cyc), 41'(12));

    // Continuous-run instance: T5 loops to T0 while run is high.
    start_c = 1'b1; run_c = 1'b1;
    done_first = 0; done_second = 0; done_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      start_c = 1'b0;
      if (c == 9) run_c = 1'b0;
      if (done_c) begin
        done_cnt++;
        if (done_cnt == 1) done_first = c; else if (done_cnt == 2) done_second = c;
      end
      if (c == 7) check("cont_T5_to_T0", {37'h0, pco_c, mar_c, inc_c, zrd_c}, 41'hf);
      if (c == 13) check("cont_idle_busy", {40'h0, busy_c}, 41'h0);
    end
    check("cont_done_first", 41'(done_first), 41'(6));
    check("cont_done_second", 41'(done_second), 41'(12));
    check("cont_done_count", 41'(done_cnt), 41'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
